// File: rtl/uart_tx_if.sv
// UART transmit port bundle: byte request in, serial line and status out.
// Latency: none (wires only).
// Backpressure: the requester watches busy; requests made while busy are dropped.
interface uart_tx_if;
    logic [7:0] data;
    logic       send;
    logic       tx;
    logic       busy;
    logic       send_finish;

    modport master (
        output data,
        output send,
        input  tx,
        input  busy,
        input  send_finish
    );

    modport slave (
        input  data,
        input  send,
        output tx,
        output busy,
        output send_finish
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 8 data bits LSB first, [even parity], stop bit.
// Latency: tx drops on the edge that samples send; frame is 10 (11 with parity) bits of CLKS_PER_BIT cycles.
// Backpressure: send is only honoured in IDLE; while busy it is ignored, with no queueing.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  u
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] clk_count_q, clk_count_d;
    logic [2:0] bit_count_q, bit_count_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       send_finish_q, send_finish_d;

    logic       bit_end;
    logic [2:0] next_bit;

    assign bit_end  = (clk_count_q == LAST_CLK);
    assign next_bit = bit_count_q + 3'd1;

    // State register and all output/counter flops; reset forces an idle-high line at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            clk_count_q   <= 8'd0;
            bit_count_q   <= 3'd0;
            shift_q       <= 8'd0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            send_finish_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_count_q   <= clk_count_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            send_finish_q <= send_finish_d;
        end
    end

    // Next-state logic: tx is computed one cycle ahead so the line itself comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        clk_count_d   = clk_count_q;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        send_finish_d = 1'b0;

        if (state_q != S_IDLE) begin
            clk_count_d = bit_end ? 8'd0 : clk_count_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (u.send) begin
                    shift_d     = u.data;
                    clk_count_d = 8'd0;
                    bit_count_d = 3'd0;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_count_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_count_d = next_bit;
                        tx_d        = shift_q[next_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    busy_d        = 1'b0;
                    send_finish_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign u.tx          = tx_q;
    assign u.busy        = busy_q;
    assign u.send_finish = send_finish_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (2 and 1 clocks per bit), scoreboard of expected bytes,
// a negedge monitor that captures each frame cycle by cycle and compares it at send_finish.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_if if0 ();
    uart_tx_if if1 ();

    uart_tx #(.CLKS_PER_BIT(2)) u0 (.clk(clk), .rst(rst), .u(if0));
    uart_tx #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .u(if1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [63:0] cap      [2];
    int          cap_len  [2];
    int          fin_cnt  [2];
    int          gap      [2];
    int          last_gap [2];
    logic        prev_fin [2];
    logic        prev_busy[2];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line, one entry per clock: bit i of the result is tx during cycle i of the frame.
    function automatic logic [63:0] exp_line(input logic [7:0] b, input int cpb);
        logic [63:0] line;
        logic [10:0] fb;
        line = 64'd0;
        fb   = 11'd0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        fb[9]  = ^b;
        fb[10] = 1'b1;
`else
        fb[9]  = 1'b1;
`endif
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < cpb; j++)
                line[i*cpb+j] = fb[i];
        return line;
    endfunction

    task automatic mon_step(input int id, input int cpb, input logic tx, input logic busy,
                            input logic fin);
        logic [7:0]  eb;
        logic        have;
        logic [63:0] el;
        if (!rst) begin
            cap[id]       = 64'd0;
            cap_len[id]   = 0;
            prev_fin[id]  = 1'b0;
            prev_busy[id] = 1'b0;
        end else begin
            if (busy) begin
                if (!prev_busy[id]) last_gap[id] = gap[id];
                gap[id] = 0;
                if (cap_len[id] < 64) cap[id][cap_len[id]] = tx;
                cap_len[id]++;
            end else begin
                gap[id]++;
                check(tx == 1'b1, "idle_tx_high", 64'(tx), 64'd1);
            end
            if (fin) begin
                fin_cnt[id]++;
                check(!prev_fin[id], "finish_one_cycle", 64'(prev_fin[id]), 64'd0);
                check(!busy, "finish_with_busy_low", 64'(busy), 64'd0);
                have = 1'b0;
                eb   = 8'd0;
                if (id == 0 && q0.size() > 0) begin eb = q0.pop_front(); have = 1'b1; end
                if (id == 1 && q1.size() > 0) begin eb = q1.pop_front(); have = 1'b1; end
                check(have, "frame_expected", 64'(fin_cnt[id]), 64'd0);
                if (have) begin
                    el = exp_line(eb, cpb);
                    check(cap_len[id] == NB * cpb, "busy_cycles", 64'(cap_len[id]), 64'(NB * cpb));
                    check(cap[id] == el, "line_pattern", cap[id], el);
                end
                cap[id]     = 64'd0;
                cap_len[id] = 0;
            end
            prev_fin[id]  = fin;
            prev_busy[id] = busy;
        end
    endtask

    // Monitor: samples both DUTs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_step(0, 2, if0.tx, if0.busy, if0.send_finish);
        mon_step(1, 1, if1.tx, if1.busy, if1.send_finish);
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fin(input int id, input int target, input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (fin_cnt[id] >= target) break;
            cyc(1);
        end
        if (i == 400) check(1'b0, name, 64'(fin_cnt[id]), 64'(target));
    endtask

    task automatic pulse0(input logic [7:0] b);
        if0.data = b;
        if0.send = 1'b1;
        cyc(1);
        if0.send = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int f0;
        for (int i = 0; i < 2; i++) begin
            cap[i] = 64'd0; cap_len[i] = 0; fin_cnt[i] = 0;
            gap[i] = 0; last_gap[i] = 0; prev_fin[i] = 1'b0; prev_busy[i] = 1'b0;
        end
        if0.data = 8'h00; if0.send = 1'b0;
        if1.data = 8'h00; if1.send = 1'b0;

        // Reset held: send toggling must not disturb the idle outputs.
        #1;
        for (int i = 0; i < 4; i++) begin
            if0.send = ~if0.send;
            cyc(1);
            check(if0.tx == 1'b1,          "rst_tx",     64'(if0.tx),          64'd1);
            check(if0.busy == 1'b0,        "rst_busy",   64'(if0.busy),        64'd0);
            check(if0.send_finish == 1'b0, "rst_finish", 64'(if0.send_finish), 64'd0);
        end
        if0.send = 1'b0;
        rst = 1'b1;
        cyc(2);

        // Single frame of A5.
        f0 = fin_cnt[0];
        q0.push_back(8'hA5);
        pulse0(8'hA5);
        check(if0.tx == 1'b0 && if0.busy == 1'b1, "start_latency", {62'd0, if0.tx, if0.busy}, 64'd1);
        wait_fin(0, f0 + 1, "timeout_a5");
        cyc(3);
        check(fin_cnt[0] == f0 + 1, "a5_finish_count", 64'(fin_cnt[0] - f0), 64'd1);

        // Single frame of 01 (parity 1 when enabled).
        f0 = fin_cnt[0];
        q0.push_back(8'h01);
        pulse0(8'h01);
        wait_fin(0, f0 + 1, "timeout_01");
        cyc(3);

        // Re-request with FF while 3C is in flight: must be ignored.
        f0 = fin_cnt[0];
        q0.push_back(8'h3C);
        pulse0(8'h3C);
        cyc(5);
        pulse0(8'hFF);
        wait_fin(0, f0 + 1, "timeout_3c");
        cyc(10);
        check(fin_cnt[0] == f0 + 1, "ignored_send_finish_count", 64'(fin_cnt[0] - f0), 64'd1);

        // send held high: two back-to-back frames of 00 with one idle cycle between.
        f0 = fin_cnt[0];
        q0.push_back(8'h00);
        q0.push_back(8'h00);
        if0.data = 8'h00;
        if0.send = 1'b1;
        wait_fin(0, f0 + 1, "timeout_b2b_first");
        cyc(3);
        if0.send = 1'b0;
        wait_fin(0, f0 + 2, "timeout_b2b_second");
        cyc(10);
        check(fin_cnt[0] == f0 + 2, "b2b_finish_count", 64'(fin_cnt[0] - f0), 64'd2);
        check(last_gap[0] == 1, "b2b_idle_gap", 64'(last_gap[0]), 64'd1);

        // Reset asserted during the start bit: line returns high before the next edge.
        f0 = fin_cnt[0];
        pulse0(8'h3C);
        check(if0.tx == 1'b0, "abort_in_start", 64'(if0.tx), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check(if0.tx == 1'b1,   "abort_tx_async",   64'(if0.tx),   64'd1);
        check(if0.busy == 1'b0, "abort_busy_async", 64'(if0.busy), 64'd0);
        cyc(2);
        rst = 1'b1;
        cyc(40);
        check(fin_cnt[0] == f0, "abort_no_resume", 64'(fin_cnt[0] - f0), 64'd0);
        check(if0.busy == 1'b0, "abort_idle_after", 64'(if0.busy), 64'd0);

        // One clock per bit, byte 80.
        q1.push_back(8'h80);
        if1.data = 8'h80;
        if1.send = 1'b1;
        cyc(1);
        if1.send = 1'b0;
        wait_fin(1, 1, "timeout_cpb1");
        cyc(3);

        check(q0.size() == 0, "scoreboard0_drained", 64'(q0.size()), 64'd0);
        check(q1.size() == 0, "scoreboard1_drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
